// File: rtl/light_game_pkg.sv
// light_game_pkg: shared types and widths for the light game referee.
// Holds the referee state encoding and counter widths.
package light_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    WIN,
    LOSE
  } ref_state_t;

  localparam logic [1:0] LIVES_INIT = 2'd3;
  localparam int STEP_W = 5;
  localparam int TIME_W = 6;

endpackage

// File: rtl/sec_countdown.sv
// sec_countdown: CLK_HZ divider producing a one-second tick,
// plus the seconds-remaining down-counter that saturates at zero.
module sec_countdown
  import light_game_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_SEC = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  output logic              tick_out,
  output logic [TIME_W-1:0] time_left,
  output logic              zero_next
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0] T_INIT = TIME_W'(TIMEOUT_SEC);

  logic [CW-1:0] cnt;

  assign tick_out  = enable & (cnt == LAST);
  assign zero_next = tick_out & (time_left == TIME_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      time_left <= T_INIT;
    end else if (load) begin
      cnt       <= '0;
      time_left <= T_INIT;
    end else if (enable) begin
      cnt <= tick_out ? '0 : cnt + 1'b1;
      if (tick_out && time_left != '0)
        time_left <= time_left - 1'b1;
    end
  end

endmodule

// File: rtl/light_referee.sv
// light_referee: red-light/green-light referee (goal, grace, timeout).
// Define LIGHT_REFEREE_LIVES_EN for three lives instead of sudden death.
module light_referee
  import light_game_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GRACE_CYCLES = 12_500_000,
  parameter int GOAL_STEPS   = 15,
  parameter int TIMEOUT_SEC  = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              red,
  input  logic              green,
  input  logic              step,
  output logic              game_active,
  output logic [STEP_W-1:0] steps,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        lives,
  output logic              win,
  output logic              lose
);

  localparam logic [STEP_W-1:0] GOAL = STEP_W'(GOAL_STEPS);
  localparam logic [STEP_W-1:0] GOAL_M1 = STEP_W'(GOAL_STEPS - 1);
  localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam logic [GW-1:0] GRACE_LD = GW'(GRACE_CYCLES - 1);

  ref_state_t        state, state_d;
  logic [STEP_W-1:0] steps_d;
  logic [GW-1:0]     grace, grace_d;
  logic              red_q, red_d;
  logic              light_green, onset;
  logic              load, viol, locked;
  logic              sec_tick, sec_zero, time_up;

  assign light_green = green & ~red;
  assign onset       = ~light_green & ~red_q;
  assign time_up     = sec_tick & sec_zero;

  sec_countdown #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_SEC (TIMEOUT_SEC)
  ) u_sec (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == PLAY),
    .load      (load),
    .tick_out  (sec_tick),
    .time_left (time_left),
    .zero_next (sec_zero)
  );

`ifdef LIGHT_REFEREE_LIVES_EN
  logic [1:0] lives_q, lives_d;
  logic       lock, lock_d;
  assign locked = lock;
  assign lives  = lives_q;
`else
  assign locked = 1'b0;
  assign lives  = 2'd1;
`endif

  always_comb begin
    state_d = state;
    steps_d = steps;
    grace_d = grace;
    red_d   = ~light_green;
    load    = 1'b0;
    viol    = 1'b0;
    unique case (state)
      PLAY: begin
        if (step && light_green && steps == GOAL_M1) begin
          steps_d = GOAL;
          state_d = WIN;
        end else if (time_up) begin
          state_d = LOSE;
        end else if (step && light_green) begin
          steps_d = steps + 1'b1;
        end else if (onset) begin
          grace_d = GRACE_LD;
        end else if (grace != '0) begin
          grace_d = grace - 1'b1;
        end else if (step && !locked) begin
          viol = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = PLAY;
          steps_d = '0;
          grace_d = '0;
          red_d   = 1'b1;
          load    = 1'b1;
        end
      end
    endcase
`ifdef LIGHT_REFEREE_LIVES_EN
    lives_d = lives_q;
    lock_d  = lock & ~light_green;
    if (load) begin
      lives_d = LIVES_INIT;
      lock_d  = 1'b0;
    end
    // a non-fatal violation also mutes red steps until green returns
    if (viol) begin
      steps_d = '0;
      lives_d = lives_q - 1'b1;
      if (lives_q == 2'd1)
        state_d = LOSE;
      else
        lock_d = 1'b1;
    end
`else
    if (viol)
      state_d = LOSE;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      steps       <= '0;
      grace       <= '0;
      red_q       <= 1'b1;
      game_active <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state       <= state_d;
      steps       <= steps_d;
      grace       <= grace_d;
      red_q       <= red_d;
      game_active <= (state_d == PLAY);
      win         <= (state_d == WIN);
      lose        <= (state_d == LOSE);
    end
  end

`ifdef LIGHT_REFEREE_LIVES_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lives_q <= LIVES_INIT;
      lock    <= 1'b0;
    end else begin
      lives_q <= lives_d;
      lock    <= lock_d;
    end
  end
`endif

endmodule

// File: tb/tb_light_referee.sv
// tb_light_referee: directed tables, corner sequences and a random
// run against a cycle-count based reference model of the referee.
module tb_light_referee;

  localparam int CLK  = 10;
  localparam int G    = 3;
  localparam int GOAL = 4;
  localparam int TO   = 5;
`ifdef LIGHT_REFEREE_LIVES_EN
  localparam int LIV0 = 3;
`else
  localparam int LIV0 = 1;
`endif
  localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, red = 1'b1, green = 1'b0, step = 1'b0;
  logic       game_active, win, lose;
  logic [4:0] steps;
  logic [5:0] time_left;
  logic [1:0] lives;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state, m_steps, m_tl, m_lives, m_cyc, m_onset;
  bit m_prev_red, m_lock;

  light_referee #(
    .CLK_HZ       (CLK),
    .GRACE_CYCLES (G),
    .GOAL_STEPS   (GOAL),
    .TIMEOUT_SEC  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .red         (red),
    .green       (green),
    .step        (step),
    .game_active (game_active),
    .steps       (steps),
    .time_left   (time_left),
    .lives       (lives),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_state    = M_IDLE;
    m_steps    = 0;
    m_tl       = TO;
    m_lives    = LIV0;
    m_cyc      = 0;
    m_onset    = -1000;
    m_prev_red = 1'b1;
    m_lock     = 1'b0;
  endfunction

  function automatic void model_viol();
`ifdef LIGHT_REFEREE_LIVES_EN
    m_steps = 0;
    if (m_lives == 1) begin
      m_lives = 0;
      m_state = M_LOSE;
    end else begin
      m_lives--;
      m_lock = 1'b1;
    end
`else
    m_state = M_LOSE;
`endif
  endfunction

  // Time and grace are derived from elapsed PLAY cycles, not counters.
  function automatic void model_step(bit s, bit r, bit g, bit st);
    bit lg = g && !r;
    bit onset = !lg && !m_prev_red;
    bit tick;
    bit ignored;
    if (m_state == M_PLAY) begin
      tick = (m_cyc % CLK) == CLK - 1;
      if (onset) m_onset = m_cyc;
      ignored = (m_cyc - m_onset) < G;
      if (st && lg && m_steps == GOAL - 1) begin
        m_steps = GOAL;
        m_state = M_WIN;
      end else if (tick && m_tl == 1) begin
        m_state = M_LOSE;
      end else if (st && lg) begin
        m_steps++;
      end else if (st && !ignored && !m_lock) begin
        model_viol();
      end
      if (lg) m_lock = 1'b0;
      if (tick && m_tl > 0) m_tl--;
      m_cyc++;
      m_prev_red = !lg;
    end else if (s) begin
      m_state    = M_PLAY;
      m_steps    = 0;
      m_tl       = TO;
      m_lives    = LIV0;
      m_cyc      = 0;
      m_onset    = -1000;
      m_lock     = 1'b0;
      m_prev_red = 1'b1;
    end else begin
      m_prev_red = !lg;
    end
  endfunction

  function automatic void check_model(string name);
    chk({name, ".active"}, game_active, m_state == M_PLAY);
    chk({name, ".steps"}, steps, m_steps);
    chk({name, ".time_left"}, time_left, m_tl);
    chk({name, ".lives"}, lives, m_lives);
    chk({name, ".win"}, win, m_state == M_WIN);
    chk({name, ".lose"}, lose, m_state == M_LOSE);
  endfunction

  task automatic cyc(bit s, bit r, bit g, bit st);
    start = s;
    red   = r;
    green = g;
    step  = st;
    model_step(s, r, g, st);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0;
    step  = 1'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit s, r, g, st;
    int e_steps;
    bit e_act, e_win;
    int e_tl;
  } vec_t;

  vec_t tbl[9];
  bit   cr, cg;

  initial begin
    tbl[0] = '{1, 0, 1, 0, 0, 1, 0, 5};
    tbl[1] = '{0, 0, 1, 1, 1, 1, 0, 5};
    tbl[2] = '{0, 0, 1, 0, 1, 1, 0, 5};
    tbl[3] = '{0, 0, 1, 1, 2, 1, 0, 5};
    tbl[4] = '{0, 0, 1, 0, 2, 1, 0, 5};
    tbl[5] = '{0, 0, 1, 1, 3, 1, 0, 5};
    tbl[6] = '{0, 0, 1, 0, 3, 1, 0, 5};
    tbl[7] = '{0, 0, 1, 1, 4, 0, 1, 5};
    tbl[8] = '{0, 0, 1, 0, 4, 0, 1, 5};

    model_reset();
    #12;
    chk("rst.active", game_active, 0);
    chk("rst.steps", steps, 0);
    chk("rst.time_left", time_left, TO);
    chk("rst.lives", lives, LIV0);
    chk("rst.win", win, 0);
    chk("rst.lose", lose, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s, tbl[i].r, tbl[i].g, tbl[i].st);
      chk($sformatf("goal[%0d].steps", i), steps, tbl[i].e_steps);
      chk($sformatf("goal[%0d].active", i), game_active, tbl[i].e_act);
      chk($sformatf("goal[%0d].win", i), win, tbl[i].e_win);
      chk($sformatf("goal[%0d].tl", i), time_left, tbl[i].e_tl);
    end

    // restart from WIN, then red-onset grace window
    cyc(1, 0, 1, 0);
    chk("grace.restart_active", game_active, 1);
    chk("grace.restart_steps", steps, 0);
    cyc(0, 0, 1, 1);
    chk("grace.green_step", steps, 1);
    cyc(0, 1, 0, 1);
    chk("grace.onset_steps", steps, 1);
    chk("grace.onset_lose", lose, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("grace.p2_steps", steps, 1);
    chk("grace.p2_lose", lose, 0);
    cyc(0, 1, 0, 1);
`ifdef LIGHT_REFEREE_LIVES_EN
    chk("grace.viol_lives", lives, 2);
    chk("grace.viol_steps", steps, 0);
    chk("grace.viol_lose", lose, 0);
`else
    chk("grace.viol_lose", lose, 1);
    chk("grace.viol_active", game_active, 0);
`endif

    do_reset();
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 50; k++) begin
      cyc(0, 0, 1, 0);
      if (k == 9) chk("tmo.tl_after_1s", time_left, 4);
      if (k == 48) begin
        chk("tmo.tl_before_end", time_left, 1);
        chk("tmo.lose_before_end", lose, 0);
      end
    end
    chk("tmo.lose", lose, 1);
    chk("tmo.tl_zero", time_left, 0);
    chk("tmo.active", game_active, 0);

    do_reset();
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 50; k++)
      cyc(0, 0, 1, (k < 3) || (k == 49));
    chk("tmo_goal.win", win, 1);
    chk("tmo_goal.lose", lose, 0);
    chk("tmo_goal.steps", steps, 4);

    do_reset();
    cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    chk("illegal.grace_lose", lose, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
`ifdef LIGHT_REFEREE_LIVES_EN
    chk("illegal.viol_lives", lives, 2);
`else
    chk("illegal.viol_lose", lose, 1);
`endif

    do_reset();
    cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("midrst.pre_steps", steps, 2);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst.steps", steps, 0);
    chk("midrst.tl", time_left, TO);
    chk("midrst.active", game_active, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 0, 1, 0);
    chk("midrst.restart_active", game_active, 1);
    chk("midrst.restart_steps", steps, 0);
    chk("midrst.restart_tl", time_left, TO);

`ifdef LIGHT_REFEREE_LIVES_EN
    do_reset();
    cyc(1, 0, 1, 0);
    chk("lives.init", lives, 3);
    for (int v = 0; v < 3; v++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 1);
      chk($sformatf("lives.v%0d", v), lives, 2 - v);
      chk($sformatf("lives.lose%0d", v), lose, v == 2);
    end
`endif

    do_reset();
    cr = 1'b1;
    cg = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cr = 1'($urandom_range(0, 1));
        cg = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(0, 29) == 0, cr, cg, $urandom_range(0, 2) == 0);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/light_referee.md
Name: light_referee

Overview:
- Game referee that consumes the red/green outputs of the traffic light and the player's step pulses.
- Decides win or lose, and drives `game_active` back to the light so the light only cycles during play.
- Sits between the debounced player input and the HEX/LED display logic.
- Enforces a reaction-grace window after each red onset, a step goal and an overall time limit.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second; sets the second tick.
- GRACE_CYCLES, 12_500_000, cycles after red onset during which steps are ignored (250 ms).
- GOAL_STEPS, 15, steps needed to win. Legal range 1..31.
- TIMEOUT_SEC, 60, game length in seconds. Legal range 1..63.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle pulse that begins a game.
- red  in  1  traffic light red.
- green  in  1  traffic light green.
- step  in  1  single-cycle, already-synchronized player step pulse.
- game_active  out  1  high while in PLAY; feeds the traffic light.
- steps  out  5  steps counted this game.
- time_left  out  6  seconds remaining.
- lives  out  2  remaining lives.
- win  out  1  level, high in WIN.
- lose  out  1  level, high in LOSE.

Behaviour:
- Reset values (reset=0):
  - state IDLE; game_active=0, steps=0, time_left=TIMEOUT_SEC, win=0, lose=0.
  - lives=3 with LIVES_EN, else 1.
  - grace counter=0, second counter=0, red_q=1.
- Light interpretation: `light_is_green = green & ~red`. Any other combination (both high, both low) counts as red.
- red_q registers `~light_is_green` every cycle. A red onset is `~light_is_green & ~red_q`.
- States: IDLE, PLAY, WIN, LOSE.
- IDLE:
  - start -> PLAY.
  - On that transition: steps=0, time_left=TIMEOUT_SEC, counters cleared, lives reloaded.
  - red_q is forced to 1 so no grace opens on the entry cycle.
- PLAY: `game_active=1`. Evaluated each cycle, highest priority first:
  1. Goal: step on green with steps==GOAL_STEPS-1 -> steps=GOAL_STEPS, go to WIN.
  2. Timeout: second tick with time_left==1 -> time_left=0, go to LOSE.
  3. Step on green -> steps+1.
  4. Red onset -> grace counter loads GRACE_CYCLES-1. A step in this same cycle is ignored.
  5. Grace counter nonzero -> decrement it; steps ignored.
  6. Step on red with grace counter ==0 -> violation (see Optional Feature).
- Second tick: fires when the second counter reaches CLK_HZ-1, then the counter wraps to 0. time_left decrements on each tick and never goes below 0.
- Simultaneous goal and timeout: WIN wins.
- start while in PLAY is ignored.
- WIN/LOSE:
  - Outputs hold; game_active=0; counters frozen.
  - start -> PLAY with a full reload, same as from IDLE.
- Timing: all outputs registered. win/lose assert 1 cycle after the deciding step or tick.
- Reset mid-game returns immediately to the reset values.

Optional Feature:
- Macro: LIGHT_REFEREE_LIVES_EN.
- Defined: 3 lives.
  - A violation decrements lives and clears steps to 0.
  - If lives was 1, the violation sets lives to 0 and goes to LOSE.
  - After a non-fatal violation, further steps are ignored until the next green.
- Undefined: lives is tied to 1, and any violation goes straight to LOSE.

Decomposition:
- Package `light_game_pkg` holds:
  - the state enum `ref_state_t` (IDLE, PLAY, WIN, LOSE);
  - `LIVES_INIT=2'd3`;
  - the width localparams `STEP_W=5` and `TIME_W=6`.
- One sub-module, `sec_countdown`:
  - holds the CLK_HZ tick counter plus the time_left down-counter;
  - ports: enable, load, tick_out, time_left, zero_next.
- The referee FSM instantiates `sec_countdown`.

Test Plan (sim overrides: CLK_HZ=10, GRACE_CYCLES=3, GOAL_STEPS=4, TIMEOUT_SEC=5):
- Goal: reset, start, green held, 4 step pulses 2 cycles apart -> steps 1,2,3,4; win=1 one cycle after the 4th step; game_active=0.
- Grace: green->red transition, step at onset +0 and +2 cycles -> steps unchanged, lose=0. Step at onset +3 -> violation; lose=1 without the macro, or lives 3->2 and steps=0 with the macro.
- Timeout: start, no steps -> time_left goes 5..1 each 10 cycles; lose=1 at cycle 50. Step on green in that tick cycle with steps==3 -> win=1 instead.
- Illegal light (red=1, green=1) after grace, step -> treated as red, violation.
- Reset asserted mid-PLAY with steps=2 -> steps=0, time_left=5, game_active=0 asynchronously. start then restarts cleanly.
- LIVES_EN: three post-grace red violations -> lives 3,2,1,0; lose=1 on the third.
